// File: rtl/decade_counter.sv
// Decimal 0-9 up/down counter with prescaler, synchronous load and step input.
// Define DECADE_COUNTER_STEP_SYNC_EN to treat step as an async button (sync + edge detect).
module decade_counter #(
    parameter int unsigned DIV = 50_000_000,
    parameter int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       step,
    output logic [3:0] Count_out,
    output logic       tick,
    output logic       carry
);

    localparam logic [PW-1:0] PCNT_MAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic          expire;
    logic          step_adv;
    logic          advance;
    logic [3:0]    next_digit;
    logic          wrap;

`ifdef DECADE_COUNTER_STEP_SYNC_EN
    logic step_meta, step_sync, step_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
        end
    end

    assign step_adv = step_sync & ~step_prev;
`else
    assign step_adv = step;
`endif

    assign expire  = en && (pcnt == PCNT_MAX);
    assign advance = expire || step_adv;

    always_comb begin
        next_digit = Count_out;
        wrap       = 1'b0;
        if (up) begin
            if (Count_out >= 4'd9) begin
                next_digit = 4'd0;
                wrap       = 1'b1;
            end else begin
                next_digit = Count_out + 4'd1;
            end
        end else begin
            if (Count_out == 4'd0) begin
                next_digit = 4'd9;
                wrap       = 1'b1;
            end else begin
                next_digit = Count_out - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            Count_out <= 4'd0;
            tick      <= 1'b0;
            carry     <= 1'b0;
        end else if (load) begin
            // Load discards any coincident advance and restarts the prescaler phase.
            pcnt      <= '0;
            Count_out <= (load_val <= 4'd9) ? load_val : 4'd0;
            tick      <= 1'b0;
            carry     <= 1'b0;
        end else begin
            if (en) begin
                pcnt <= expire ? '0 : pcnt + 1'b1;
            end
            tick  <= expire;
            carry <= advance && wrap;
            if (advance) begin
                Count_out <= next_digit;
            end
        end
    end

endmodule

// File: tb/tb_decade_counter.sv
// Directed self-checking bench for decade_counter with DIV=4.
// Covers both builds of DECADE_COUNTER_STEP_SYNC_EN.
module tb_decade_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       step;
    logic [3:0] Count_out;
    logic       tick;
    logic       carry;

    int n_compared;
    int n_mismatched;
    int base;

    decade_counter #(.DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .step      (step),
        .Count_out (Count_out),
        .tick      (tick),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got {count,tick,carry}=0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int c, input bit t, input bit cy);
        logic [31:0] got;
        logic [31:0] exp;
        got = {26'd0, Count_out, tick, carry};
        exp = {26'd0, 4'(c), t, cy};
        check(tag, got, exp);
    endtask

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n    = 1'b0;
        en       = 1'b1;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 4'd0;
        step     = 1'b0;

        // Reset and free run up
        repeat (2) step_clk;
        expect_state("reset_hold", 0, 0, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            step_clk;
            expect_state($sformatf("free_up_%0d", e), (e / 4) % 10, (e % 4) == 0,
                         ((e % 4) == 0) && (((e / 4) % 10) == 0));
        end

        // Down count with borrow
        up = 1'b0;
        load = 1'b1;
        load_val = 4'd0;
        step_clk;
        expect_state("load_zero", 0, 0, 0);
        load = 1'b0;
        repeat (3) step_clk;
        expect_state("down_pre", 0, 0, 0);
        step_clk;
        expect_state("down_borrow", 9, 1, 1);
        step_clk;
        expect_state("down_borrow_end", 9, 0, 0);

        // Load coincident with expiry, then clamp
        repeat (2) step_clk;
        load = 1'b1;
        load_val = 4'd7;
        step_clk;
        expect_state("load_over_expiry", 7, 0, 0);
        load = 1'b0;
        repeat (3) step_clk;
        expect_state("load_restart_pre", 7, 0, 0);
        step_clk;
        expect_state("load_restart_tick", 6, 1, 0);
        load = 1'b1;
        load_val = 4'd12;
        step_clk;
        expect_state("load_clamp", 0, 0, 0);
        load = 1'b0;

        // Enable hold at pcnt=2
        repeat (2) step_clk;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk;
            expect_state($sformatf("en_hold_%0d", i), 0, 0, 0);
        end
        en = 1'b1;
        step_clk;
        expect_state("reen_1", 0, 0, 0);
        step_clk;
        expect_state("reen_2", 9, 1, 1);
        up = 1'b1;

        // Step path with prescaler stopped
        en = 1'b0;
        load = 1'b1;
        load_val = 4'd3;
        step_clk;
        expect_state("load_three", 3, 0, 0);
        load = 1'b0;
        step = 1'b1;
`ifdef DECADE_COUNTER_STEP_SYNC_EN
        for (int i = 1; i <= 20; i++) begin
            step_clk;
            expect_state($sformatf("step_hold_%0d", i), (i >= 3) ? 4 : 3, 0, 0);
        end
        base = 4;
`else
        for (int i = 1; i <= 3; i++) begin
            step_clk;
            expect_state($sformatf("step_pulse_%0d", i), 3 + i, 0, 0);
        end
        base = 6;
`endif
        step = 1'b0;
        repeat (3) step_clk;
        expect_state("step_idle", base, 0, 0);

        // Step coincident with expiry gives a single advance
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd2;
        step_clk;
        expect_state("load_two", 2, 0, 0);
        load = 1'b0;
`ifdef DECADE_COUNTER_STEP_SYNC_EN
        step_clk;
        step = 1'b1;
        repeat (2) step_clk;
`else
        repeat (3) step_clk;
        step = 1'b1;
`endif
        expect_state("coinc_pre", 2, 0, 0);
        step_clk;
        expect_state("coinc_adv", 3, 1, 0);
`ifndef DECADE_COUNTER_STEP_SYNC_EN
        step = 1'b0;
`endif
        repeat (3) step_clk;
        expect_state("coinc_after", 3, 0, 0);
        step_clk;
        expect_state("coinc_next_tick", 4, 1, 0);
        step = 1'b0;

        // Async reset mid-count while tick is high
        load = 1'b1;
        load_val = 4'd5;
        step_clk;
        expect_state("load_five", 5, 0, 0);
        load = 1'b0;
        repeat (3) step_clk;
        step_clk;
        expect_state("pre_reset", 6, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        expect_state("async_reset", 0, 0, 0);
        step_clk;
        rst_n = 1'b1;
        repeat (3) step_clk;
        expect_state("post_reset_pre", 0, 0, 0);
        step_clk;
        expect_state("post_reset_tick", 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/decade_counter.md
# decade_counter

Registered decimal (0-9) up/down counter with a clock-enable prescaler, synchronous load and an optional push-button step input. It drives the 4-bit `Count_out` digit into the seven-segment decoder stage downstream. It also provides a wrap/borrow `carry` pulse so several instances can be chained into multi-digit displays.

## Interface
- `DIV`, default 50_000_000: prescaler period in `clk` cycles between automatic advances. Legal range is ≥1.
- `PW`, default `$clog2(DIV)` (minimum 1): prescaler register width. Derived; not overridden by users.
- `clk` in 1: sole clock. All state changes on the rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `en` in 1: prescaler run enable. Level-sensitive.
- `up` in 1: direction. 1 = increment, 0 = decrement. Sampled on each advance.
- `load` in 1: synchronous load strobe.
- `load_val` in 4: value to load.
- `step` in 1: manual single advance request.
- `Count_out` out 4: current digit, always within 0-9.
- `tick` out 1: one-cycle pulse when the prescaler expires.
- `carry` out 1: one-cycle pulse when the digit wraps (9→0 up, 0→9 down).

## Operation
- Prescaler `pcnt` (PW bits):
  - While `en`=1, counts 0..DIV-1. At DIV-1 it returns to 0 and asserts the internal expiry.
  - While `en`=0, it holds its value.
  - With DIV=1, expiry occurs on every cycle that `en`=1.
- Advance event = prescaler expiry OR step pulse (see Configuration).
  - Expiry and step in the same cycle produce exactly one advance, not two.
  - Step advances regardless of `en`.
- Priority per cycle: reset > `load` > advance > hold.
- Load:
  - `Count_out` ← `load_val` if `load_val` ≤ 9, else 0.
  - `pcnt` ← 0.
  - `tick` and `carry` are 0 that cycle; any concurrent advance is discarded.
- Advance up: 0→1→…→9→0. The 9→0 transition asserts `carry`.
- Advance down: 9→8→…→0→9. The 0→9 transition asserts `carry` (borrow).
- `up` is sampled in the advance cycle. A direction change takes effect on the next advance, with no extra step.
- Reset values: `Count_out`=0, `tick`=0, `carry`=0, `pcnt`=0, synchronizer/edge registers=0.
- Reset mid-operation clears all state immediately. After release, counting restarts from `pcnt`=0: the first expiry is DIV enabled cycles later.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Expiry: on the edge where `en`=1 and `pcnt`=DIV-1:
  - `pcnt` ← 0.
  - `tick` ← 1.
  - `Count_out` updates on the same edge.
  - `tick` is therefore high during the first cycle the new digit is visible.
- `tick` and `carry` are high for exactly one cycle and return to 0 on the next edge unless re-triggered.
- Load latency: `Count_out` shows the loaded value one edge after `load` is sampled high.
- With `en` held high, the spacing between `tick` pulses is exactly DIV cycles.
- `rst_n` deassertion is synchronized externally; the block does not resynchronize it.

## Configuration
- Macro: `DECADE_COUNTER_STEP_SYNC_EN`.
- Defined:
  - `step` is an asynchronous button level.
  - It passes through a 2-flop synchronizer, then a rising-edge detector register.
  - One advance per 0→1 transition, held high or not.
  - The advance occurs on the 3rd rising `clk` edge after `step` rises (the first edge sampling it high).
- Undefined:
  - `step` is a synchronous, already-conditioned pulse.
  - Each cycle `step`=1 is sampled causes one advance on that same edge, so holding it high advances every cycle.

## Test plan
- Reset and free run up: DIV=4, `en`=1, `up`=1, release `rst_n` → `Count_out` is 0 for 4 cycles, then 1, 2 … 9, 0. `tick` is high every 4th cycle. `carry` is high only in the first cycle of the 9→0 wrap.
- Down count with borrow: DIV=4, `up`=0, load 0 → next expiry gives `Count_out`=9 with `carry`=1 and `tick`=1 in the same cycle.
- Load priority and clamp:
  - `load`=1 with `load_val`=7 coincident with expiry → `Count_out`=7 next cycle, `tick`=0, `carry`=0, `pcnt` restarts (next tick 4 cycles later).
  - `load_val`=12 → `Count_out`=0.
- Enable hold: deassert `en` at `pcnt`=2 for 10 cycles → no `tick`, `Count_out` frozen. Re-enable → `tick` exactly 2 cycles later.
- Step path:
  - Macro undefined: `en`=0, 3-cycle `step` pulse → `Count_out` +3.
  - Macro defined: hold `step` for 20 cycles → exactly +1, appearing on the 3rd edge.
  - `step` coincident with expiry → single advance.
- Async reset mid-count: assert `rst_n`=0 between edges at `Count_out`=6 → `Count_out`, `tick`, `carry` go to 0 immediately without waiting for a clock edge.
